// File: rtl/bus_arbiter_8x1.sv
// Round-robin 8:1 bus arbiter with packet-locked grants, zero-gap handover
// and an idle watchdog that reclaims the bus from a stalled owner.
module bus_arbiter_8x1 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] last,
  input  logic       bus_ready,
  output logic [2:0] select,
  output logic [7:0] grant,
  output logic       bus_valid,
  output logic       bus_last,
  output logic       busy,
  output logic       abort
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned SW   = 3;
  localparam int unsigned CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t         state, state_n;
  logic [SW-1:0]  ptr, ptr_n;
  logic [SW-1:0]  select_n;
  logic [NREQ-1:0] grant_n;
  logic           abort_n;
  logic [CW-1:0]  cnt, cnt_n;

  logic [NREQ-1:0] cand;
  logic            found;
  logic [SW-1:0]   win;
  logic [SW-1:0]   idx;
  logic            owner_req;
  logic            rel_last;
  logic            rel_timeout;

  assign busy      = (state == OWNED);
  assign owner_req = req[select];
  assign bus_valid = busy & owner_req;
  assign bus_last  = busy & owner_req & last[select];

  // Rotating priority search; the current owner is masked so a release hands over.
  always_comb begin
    cand  = req & ~grant;
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + SW'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign rel_last    = bus_valid & bus_ready & bus_last;
  assign rel_timeout = busy & ~owner_req & (cnt == CW'(TIMEOUT - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    select_n = select;
    grant_n  = grant;
    abort_n  = 1'b0;
    cnt_n    = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_n  = OWNED;
          select_n = win;
          grant_n  = NREQ'(1) << win;
          ptr_n    = win + SW'(1);
          cnt_n    = '0;
        end
      end
      OWNED: begin
        if (rel_last || rel_timeout) begin
          abort_n = rel_timeout & ~rel_last;
          cnt_n   = '0;
          if (found) begin
            select_n = win;
            grant_n  = NREQ'(1) << win;
            ptr_n    = win + SW'(1);
          end else begin
            state_n  = IDLE;
            select_n = '0;
            grant_n  = '0;
          end
        end else if (owner_req) begin
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      select <= '0;
      grant  <= '0;
      abort  <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      select <= select_n;
      grant  <= grant_n;
      abort  <= abort_n;
      cnt    <= cnt_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_8x1.sv
// Directed self-checking bench for bus_arbiter_8x1 (TIMEOUT = 16).
module tb_bus_arbiter_8x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] last;
  logic       bus_ready;
  logic [2:0] select;
  logic [7:0] grant;
  logic       bus_valid;
  logic       bus_last;
  logic       busy;
  logic       abort;

  int checks = 0;
  int errors = 0;

  bus_arbiter_8x1 #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .bus_ready(bus_ready),
    .select(select), .grant(grant), .bus_valid(bus_valid), .bus_last(bus_last),
    .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] g, input logic [2:0] s,
                           input logic b, input logic v, input logic a);
    chk8({tag, " grant"}, grant, g);
    chk8({tag, " select"}, 8'(select), 8'(s));
    chk8({tag, " busy"}, 8'(busy), 8'(b));
    chk8({tag, " bus_valid"}, 8'(bus_valid), 8'(v));
    chk8({tag, " abort"}, 8'(abort), 8'(a));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst_n released 1 time unit after an edge: that cycle is cycle 0.
  task automatic do_reset();
    rst_n = 1'b0; req = '0; last = '0; bus_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with all requests high
    rst_n = 1'b0; req = 8'hFF; last = 8'h00; bus_ready = 1'b0;
    tick(); tick(); #1;
    chk_state("rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    chk8("rst bus_last", 8'(bus_last), 8'd0);
    rst_n = 1'b1; #1;
    chk_state("rst c0", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(); #1;
    chk_state("rst c1", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);

    // Single 3-beat packet from requester 5, then pointer lands on 6
    do_reset();
    req = 8'h20; bus_ready = 1'b1; #1;
    chk_state("pkt c0", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(); #1;
    chk_state("pkt b1", 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
    chk8("pkt b1 last", 8'(bus_last), 8'd0);
    tick(); #1;
    chk_state("pkt b2", 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
    tick(); last = 8'h20; #1;
    chk_state("pkt b3", 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
    chk8("pkt b3 last", 8'(bus_last), 8'd1);
    tick(); req = 8'hFF; last = 8'h00; #1;
    chk_state("pkt idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(); #1;
    chk_state("pkt ptr6", 8'h40, 3'd6, 1'b1, 1'b1, 1'b0);

    // Round robin of single-beat packets, no gaps
    do_reset();
    req = 8'hFF; last = 8'hFF; bus_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(); #1;
      chk_state($sformatf("rr c%0d", k), 8'(8'h01 << ((k - 1) % 8)),
                3'((k - 1) % 8), 1'b1, 1'b1, 1'b0);
    end

    // Lock through consumer stalls and requester bubbles
    do_reset();
    req = 8'h04; bus_ready = 1'b1;
    tick(); req = 8'h84; #1;
    chk_state("lock c1", 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);
    tick(); bus_ready = 1'b0; #1;
    chk_state("lock c2", 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);
    tick(); bus_ready = 1'b1; req = 8'h80; #1;
    chk_state("lock c3", 8'h04, 3'd2, 1'b1, 1'b0, 1'b0);
    tick(); bus_ready = 1'b0; #1;
    chk_state("lock c4", 8'h04, 3'd2, 1'b1, 1'b0, 1'b0);
    tick(); bus_ready = 1'b1; #1;
    chk_state("lock c5", 8'h04, 3'd2, 1'b1, 1'b0, 1'b0);
    tick(); req = 8'h84; last = 8'h04; #1;
    chk_state("lock c6", 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);
    chk8("lock c6 last", 8'(bus_last), 8'd1);
    tick(); last = 8'h00; #1;
    chk_state("lock c7", 8'h80, 3'd7, 1'b1, 1'b1, 1'b0);

    // Watchdog: owner 3 idles from cycle 1, release after 16 idle cycles
    do_reset();
    req = 8'h08; bus_ready = 1'b1;
    tick(); req = 8'h10; #1;
    chk_state("to c1", 8'h08, 3'd3, 1'b1, 1'b0, 1'b0);
    for (int k = 2; k <= 16; k++) begin
      tick(); #1;
      chk_state($sformatf("to c%0d", k), 8'h08, 3'd3, 1'b1, 1'b0, 1'b0);
    end
    tick(); #1;
    chk_state("to c17", 8'h10, 3'd4, 1'b1, 1'b1, 1'b1);
    // Second timeout with no other requester ends in IDLE
    tick(); req = 8'h00; #1;
    chk_state("to c18", 8'h10, 3'd4, 1'b1, 1'b0, 1'b0);
    for (int k = 19; k <= 33; k++) tick();
    #1;
    chk_state("to c33", 8'h10, 3'd4, 1'b1, 1'b0, 1'b0);
    tick(); #1;
    chk_state("to c34", 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    tick(); #1;
    chk_state("to c35", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a beat
    do_reset();
    req = 8'h08; bus_ready = 1'b0;
    tick(); #1;
    chk_state("ar own", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0; #1;
    chk_state("ar low", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(); rst_n = 1'b1; req = 8'h40; #1;
    chk_state("ar rel", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(); #1;
    chk_state("ar c1", 8'h40, 3'd6, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_8x1.md
# bus_arbiter_8x1

Round-robin arbiter that shares one 32-bit bus among eight requesters. It owns the 3-bit `select` that steers the 32-bit 8:1 datapath mux onto the bus, and it runs the valid/ready handshake toward the bus consumer. Once a requester is granted, the grant is held for a whole multi-beat packet. A watchdog reclaims the bus from a granted requester that stalls.

## Interface
- `TIMEOUT`, 16: consecutive idle cycles (granted requester's `req` low) before a forced release. Must be ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 8: per-requester request; high while that requester has a beat available.
- `last` input 8: per-requester end-of-packet flag, qualified by `req` of the same index.
- `bus_ready` input 1: consumer accepts the current beat.
- `select` output 3: index of the granted requester; drives the 8:1 mux select.
- `grant` output 8: one-hot grant, all-zero when idle.
- `bus_valid` output 1: beat present on the bus.
- `bus_last` output 1: current beat ends the packet.
- `busy` output 1: the bus is owned.
- `abort` output 1: one-cycle pulse after a timeout release.

## Operation
- **States:**
  - IDLE (`busy`=0).
  - OWNED (`busy`=1; `select`/`grant` hold the owner).
- **Round-robin pointer `ptr[2:0]`:**
  - Reset value is 0.
  - Search order is `ptr`, `ptr`+1, … `ptr`+7, all mod 8.
  - On every grant to index i, `ptr` ← i+1 mod 8.
- **IDLE:** if `req` is nonzero, the winner is registered at the edge and the state goes to OWNED. Otherwise stay in IDLE.
- **OWNED, combinational outputs:**
  - `bus_valid` = `req[select]`.
  - `bus_last` = `req[select]` & `last[select]`.
  - Both outputs are 0 in IDLE.
- **Transfer:** a beat transfers when `bus_valid` & `bus_ready`. The grant is locked until the transfer with `bus_last`=1. Dropping `req` mid-packet only inserts bubbles.
- **Release events:**
  - (a) a transfer with `bus_last`=1;
  - (b) a timeout.
- **Handover on release:** in the same cycle, re-arbitrate among `req` with the owner's bit masked off. If any other requester is found, go directly to OWNED with the new winner (no idle gap). Otherwise go to IDLE. The releasing requester competes again from the next cycle.
- **Watchdog counter:**
  - Width is ceil(log2(`TIMEOUT`)).
  - Cleared on entry to OWNED and in any cycle where `req[select]`=1.
  - Increments on each OWNED cycle with `req[select]`=0.
  - When it equals `TIMEOUT`-1 and `req[select]` is still 0: release (b), clear the counter, and register `abort`=1 for exactly one cycle.
  - `bus_ready` low with `bus_valid` high does not count; a consumer stall is unbounded.
- **Simultaneous events:**
  - The last-beat transfer wins over timeout. The two are mutually exclusive in any case, because a transfer requires `req[select]`=1.
  - New `req` bits arriving in a release cycle are included in that cycle's arbitration.

## Timing
- **Reset:** `select`=0, `grant`=0, `busy`=0, `abort`=0, `ptr`=0, counter=0, state IDLE. `bus_valid`=0 and `bus_last`=0 follow from `busy`=0.
- **Grant latency:** `req` first seen high at cycle N in IDLE gives `grant`/`busy` high at N+1. `bus_valid` can be high at N+1.
- **Handover:** a last-beat transfer at cycle M gives the new owner granted at M+1, so there are zero dead cycles between packets.
- **Timeout:**
  - The owner's `req` is low from cycle K onward.
  - The release edge is at the end of cycle K+`TIMEOUT`-1.
  - `abort` is high during cycle K+`TIMEOUT` only, together with the new owner or IDLE.
- **Reset mid-packet:** `rst_n` low clears all state immediately (asynchronous). No `abort` is generated. After deassertion, arbitration restarts from `ptr`=0.

## Test plan
- **Reset:** hold `rst_n`=0 with `req`=8'hFF → `grant`=0, `select`=0, `busy`=0, `bus_valid`=0. Release at cycle 0 → `grant`=8'h01 at cycle 1.
- **Single packet:** `req[5]`=1, 3 beats with `last` on beat 3, `bus_ready`=1 → `select`=5 and `grant`=8'h20 for exactly 3 cycles, then IDLE. Next `ptr`=6.
- **Round robin:** all `req` high, single-beat packets (`last`=8'hFF) → grant order 0,1,2,…,7,0 with no gap cycles.
- **Lock and stall:** owner 2 is mid-packet with `req[7]`=1; toggle `bus_ready` and drop `req[2]` for 3 cycles → `grant` stays 8'h04 until the `last` transfer; then `grant`=8'h80 on the next cycle.
- **Timeout:** with `TIMEOUT`=16, owner 3 drops `req` and `req[4]`=1 → after 16 idle cycles, `abort` pulses for 1 cycle and `grant`=8'h10 in that same cycle. `req[3]` is not regranted in that cycle.
- **Async reset mid-packet:** assert `rst_n`=0 between clock edges during a beat → all outputs are 0 immediately. After release with `req[6]` only → `grant`=8'h40 one cycle later.
